// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight,
// hands fetched words to decode and squashes wrong-path traffic on redirect.
//
// state | meaning
// IDLE  | first cycle after reset, no request presented
// REQ   | request at pc presented to imem
// WAIT  | request accepted, response pending
// HOLD  | instruction held for decode
// DROP  | wrong-path response still owed, will be discarded
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         flush_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect outranks every handshake completing in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (pc_src) begin
                    state_next = imem_req_ready ? DROP : REQ;
                end else if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (pc_src) begin
                    state_next = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (pc_src || if_ready) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == REQ);
        if_valid       = (state == HOLD);
        imem_req_addr  = pc;
        if_instr       = instr_q;
        if_pc          = instr_pc_q;
        flush          = flush_q;
    end

    assign capture = (state == WAIT) && imem_rsp_valid && !pc_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_src) begin
            pc <= align_word(pc_target);
        end else if ((state == HOLD) && if_ready) begin
            pc <= pc + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= pc_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (capture) begin
            instr_q    <= imem_rsp_data;
            instr_pc_q <= pc;
        end
    end

endmodule
